// File: rtl/fmul_pipe.sv
// Three-stage floating-point multiplier with round-to-nearest-even, flush-to-zero,
// special-value handling, exception flags and a single global valid/ready stall.
module fmul_pipe #(
  parameter int EXP        = 8,
  parameter int MANT       = 23,
  parameter int DATA_WIDTH = 1 + EXP + MANT,
  parameter int BIAS       = 2 ** (EXP - 1) - 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] c_o,
  output logic [3:0]            flags_o
);

  localparam int PW = 2 * MANT + 2;
  localparam int EW = EXP + 2;
  localparam logic signed [EW-1:0] EXP_MAX  = EW'(2 ** EXP - 1);
  localparam logic signed [EW-1:0] EXP_ZERO = '0;

  typedef enum logic [1:0] {CLS_NORM, CLS_NAN, CLS_INF, CLS_ZERO} cls_t;

  // Handshake: operands transfer on valid_i & ready_o, results on valid_o & ready_i.
  // Every stage advances together whenever the output slot is empty or being taken.
  logic w_adv;
  logic r_valid;
  assign w_adv   = ready_i | ~r_valid;
  assign ready_o = w_adv | rst_i;

  // Operand decode and classification
  logic            w_sa, w_sb;
  logic [EXP-1:0]  w_ea, w_eb;
  logic [MANT-1:0] w_fa, w_fb;
  logic            w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  cls_t            w_cls;
  logic            w_inv;
  logic [PW-1:0]   w_prod;
  logic [EW-1:0]   w_exp_sum;

  assign w_sa     = a_i[DATA_WIDTH-1];
  assign w_sb     = b_i[DATA_WIDTH-1];
  assign w_ea     = a_i[DATA_WIDTH-2:MANT];
  assign w_eb     = b_i[DATA_WIDTH-2:MANT];
  assign w_fa     = a_i[MANT-1:0];
  assign w_fb     = b_i[MANT-1:0];
  assign w_a_nan  = (&w_ea) & (|w_fa);
  assign w_b_nan  = (&w_eb) & (|w_fb);
  assign w_a_inf  = (&w_ea) & ~(|w_fa);
  assign w_b_inf  = (&w_eb) & ~(|w_fb);
  assign w_a_zero = ~(|w_ea);
  assign w_b_zero = ~(|w_eb);

  always_comb begin
    w_cls = CLS_NORM;
    w_inv = 1'b0;
    if (w_a_nan | w_b_nan | (w_a_inf & w_b_zero) | (w_a_zero & w_b_inf)) begin
      w_cls = CLS_NAN;
      w_inv = ~(w_a_nan | w_b_nan);
    end else if (w_a_inf | w_b_inf) begin
      w_cls = CLS_INF;
    end else if (w_a_zero | w_b_zero) begin
      w_cls = CLS_ZERO;
    end
  end

  assign w_prod    = PW'({1'b1, w_fa}) * PW'({1'b1, w_fb});
  assign w_exp_sum = EW'(w_ea) + EW'(w_eb) - EW'(BIAS);

  // Stage 1 registers
  logic            r1_valid, r1_inv, r1_sign;
  cls_t            r1_cls;
  logic [EW-1:0]   r1_exp;
  logic [PW-1:0]   r1_prod;

  // Normalise: product lies in [1,4), shift once if it reached [2,4)
  logic [MANT-1:0] w2_mant;
  logic            w2_g, w2_s;
  logic [EW-1:0]   w2_exp;

  always_comb begin
    if (r1_prod[PW-1]) begin
      w2_mant = r1_prod[2*MANT -: MANT];
      w2_g    = r1_prod[MANT];
      w2_s    = |r1_prod[MANT-1:0];
      w2_exp  = r1_exp + EW'(1);
    end else begin
      w2_mant = r1_prod[2*MANT-1 -: MANT];
      w2_g    = r1_prod[MANT-1];
      w2_s    = |r1_prod[MANT-2:0];
      w2_exp  = r1_exp;
    end
  end

  // Stage 2 registers
  logic            r2_valid, r2_inv, r2_sign, r2_g, r2_s;
  cls_t            r2_cls;
  logic [EW-1:0]   r2_exp;
  logic [MANT-1:0] r2_mant;

  // Round to nearest even, then range-check the rounded exponent
  logic                  w3_up, w3_carry, w3_inexact, w3_ovf, w3_unf;
  logic [MANT-1:0]       w3_mant;
  logic signed [EW-1:0]  w3_exp;
  logic [DATA_WIDTH-1:0] w3_c;
  logic [3:0]            w3_flags;

  assign w3_up               = r2_g & (r2_s | r2_mant[0]);
  assign {w3_carry, w3_mant} = {1'b0, r2_mant} + (MANT + 1)'(w3_up);
  assign w3_exp              = r2_exp + EW'(w3_carry);
  assign w3_inexact          = r2_g | r2_s;
  assign w3_ovf              = w3_exp >= EXP_MAX;
  assign w3_unf              = w3_exp <= EXP_ZERO;

  always_comb begin
    w3_c     = '0;
    w3_flags = '0;
    case (r2_cls)
      CLS_NAN: begin
        w3_c     = {1'b0, {EXP{1'b1}}, 1'b1, {(MANT - 1){1'b0}}};
        w3_flags = {r2_inv, 3'b000};
      end
      CLS_INF:  w3_c = {r2_sign, {EXP{1'b1}}, {MANT{1'b0}}};
      CLS_ZERO: w3_c = {r2_sign, {(EXP + MANT){1'b0}}};
      default: begin
        if (w3_ovf) begin
          w3_c     = {r2_sign, {EXP{1'b1}}, {MANT{1'b0}}};
          w3_flags = 4'b0101;
        end else if (w3_unf) begin
          w3_c     = {r2_sign, {(EXP + MANT){1'b0}}};
          w3_flags = 4'b0011;
        end else begin
          w3_c     = {r2_sign, w3_exp[EXP-1:0], w3_mant};
          w3_flags = {3'b000, w3_inexact};
        end
      end
    endcase
  end

  // Stage 3 (output) registers
  logic [DATA_WIDTH-1:0] r_c;
  logic [3:0]            r_flags;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r1_valid <= 1'b0; r1_inv <= 1'b0; r1_sign <= 1'b0; r1_cls <= CLS_NORM;
      r1_exp   <= '0;   r1_prod <= '0;
      r2_valid <= 1'b0; r2_inv <= 1'b0; r2_sign <= 1'b0; r2_cls <= CLS_NORM;
      r2_exp   <= '0;   r2_mant <= '0;  r2_g <= 1'b0;    r2_s <= 1'b0;
      r_valid  <= 1'b0; r_c <= '0;      r_flags <= '0;
    end else if (w_adv) begin
      r1_valid <= valid_i;
      r1_inv   <= w_inv;
      r1_sign  <= w_sa ^ w_sb;
      r1_cls   <= w_cls;
      r1_exp   <= w_exp_sum;
      r1_prod  <= w_prod;
      r2_valid <= r1_valid;
      r2_inv   <= r1_inv;
      r2_sign  <= r1_sign;
      r2_cls   <= r1_cls;
      r2_exp   <= w2_exp;
      r2_mant  <= w2_mant;
      r2_g     <= w2_g;
      r2_s     <= w2_s;
      r_valid  <= r2_valid;
      r_c      <= w3_c;
      r_flags  <= w3_flags;
    end
  end

  assign valid_o = r_valid;
  assign c_o     = r_c;
  assign flags_o = r_flags;

endmodule

// File: tb/tb_fmul_pipe.sv
// Bench for fmul_pipe: directed vectors, a half-precision instance, random streams
// against an arithmetic reference model, backpressure and mid-flight reset.
module tb_fmul_pipe;

  logic        clk = 1'b0;
  logic        rst_i, valid_i, ready_o, valid_o, ready_i;
  logic [31:0] a_i, b_i, c_o;
  logic [3:0]  flags_o;
  logic        h_valid_i, h_ready_o, h_valid_o, h_ready_i;
  logic [15:0] h_a, h_b, h_c;
  logic [3:0]  h_flags;

  int  total = 0;
  int  bad   = 0;
  int  n_out = 0;
  bit  last_in_fire;
  logic [35:0] exp_q[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [3:0]  f;
  } vec_t;
  vec_t vt[14];

  always #5 clk = ~clk;

  fmul_pipe u_dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .a_i(a_i), .b_i(b_i), .valid_o(valid_o), .ready_i(ready_i),
    .c_o(c_o), .flags_o(flags_o)
  );

  fmul_pipe #(.EXP(5), .MANT(10)) u_half (
    .clk_i(clk), .rst_i(rst_i), .valid_i(h_valid_i), .ready_o(h_ready_o),
    .a_i(h_a), .b_i(h_b), .valid_o(h_valid_o), .ready_i(h_ready_i),
    .c_o(h_c), .flags_o(h_flags)
  );

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: exact integer product, rounded by comparing the discarded remainder to half an ulp
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b);
    int     ea, eb, e, sh;
    longint fa, fb, p, q, rem, half;
    bit     s, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, inexact;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    fa = longint'(a[22:0]); fb = longint'(b[22:0]);
    s = a[31] ^ b[31];
    nan_a = (ea == 255) && (fa != 0); inf_a = (ea == 255) && (fa == 0); zero_a = (ea == 0);
    nan_b = (eb == 255) && (fb != 0); inf_b = (eb == 255) && (fb == 0); zero_b = (eb == 0);
    if (nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b))
      return {(nan_a || nan_b) ? 4'b0000 : 4'b1000, 32'h7FC00000};
    if (inf_a || inf_b) return {4'b0000, s, 8'hFF, 23'd0};
    if (zero_a || zero_b) return {4'b0000, s, 31'd0};
    p  = (fa + (64'sd1 << 23)) * (fb + (64'sd1 << 23));
    e  = ea + eb - 127;
    sh = 23;
    if (p >= (64'sd1 << 47)) begin sh = 24; e++; end
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'sd1 << (sh - 1);
    inexact = (rem != 0);
    if (rem > half || (rem == half && q[0])) q++;
    if (q == (64'sd1 << 24)) begin q = q >> 1; e++; end
    if (e >= 255) return {4'b0101, s, 8'hFF, 23'd0};
    if (e <= 0)   return {4'b0011, s, 31'd0};
    return {3'b000, inexact, s, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] gen(input bit mix);
    logic [31:0] sp[6];
    sp[0] = 32'h00000000; sp[1] = 32'h80000000; sp[2] = 32'h7F800000;
    sp[3] = 32'hFF800000; sp[4] = 32'h7FC12345; sp[5] = 32'h00000005;
    if (mix && $urandom_range(0, 7) == 0) return sp[$urandom_range(0, 5)];
    return {1'($urandom_range(0, 1)), 8'($urandom_range(40, 214)), 23'($urandom)};
  endfunction

  // One clock cycle of the streaming driver/monitor; inputs are set by the caller
  task automatic step();
    bit          hold, r;
    logic [35:0] held;
    #1;
    r = rst_i;
    hold = 1'b0;
    held = '0;
    last_in_fire = 1'b0;
    if (valid_o && ready_i && !r) begin
      n_out++;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL stray_result: actual=%h required=none", {flags_o, c_o});
      end else begin
        check("stream_result", {flags_o, c_o}, exp_q.pop_front());
      end
    end
    if (valid_o && !ready_i && !r) begin
      check("ready_o_low_in_stall", 36'(ready_o), 36'd0);
      hold = 1'b1;
      held = {flags_o, c_o};
    end
    if (valid_i && ready_o && !r) begin
      exp_q.push_back(model(a_i, b_i));
      last_in_fire = 1'b1;
    end
    @(posedge clk); #1;
    if (hold) begin
      check("stall_valid_held", 36'(valid_o), 36'd1);
      check("stall_data_held", {flags_o, c_o}, held);
    end
  endtask

  task automatic run_stream(input int n, input bit bp);
    int          sent = 0;
    int          cyc  = 0;
    bit          pending = 1'b0;
    logic [31:0] na, nb;
    n_out = 0;
    na = gen(bp); nb = gen(bp);
    while ((sent < n || n_out < n) && cyc < 600) begin
      if (!pending) pending = (sent < n) && (!bp || $urandom_range(0, 3) != 0);
      valid_i = pending; a_i = na; b_i = nb;
      if (bp) ready_i = ((cyc % 20) >= 3 && (cyc % 20) < 8) ? 1'b0 : ($urandom_range(0, 1) == 1);
      else    ready_i = 1'b1;
      step();
      if (last_in_fire) begin
        sent++; pending = 1'b0;
        na = gen(bp); nb = gen(bp);
      end
      cyc++;
    end
    valid_i = 1'b0; ready_i = 1'b1;
    check("stream_count", 36'(n_out), 36'(n));
    check("stream_queue_empty", 36'(exp_q.size()), 36'd0);
  endtask

  task automatic run_vec(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [3:0] f);
    int lat;
    valid_i = 1'b1; a_i = a; b_i = b; ready_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 10) begin @(posedge clk); #1; lat++; end
    check({name, "_latency"}, 36'(lat), 36'd3);
    check(name, {flags_o, c_o}, {f, c});
    @(posedge clk); #1;
  endtask

  task automatic run_half(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [3:0] f);
    int lat;
    h_valid_i = 1'b1; h_a = a; h_b = b;
    @(posedge clk); #1;
    h_valid_i = 1'b0;
    lat = 1;
    while (!h_valid_o && lat < 10) begin @(posedge clk); #1; lat++; end
    check({name, "_latency"}, 36'(lat), 36'd3);
    check(name, 36'({h_flags, h_c}), 36'({f, c}));
    @(posedge clk); #1;
  endtask

  initial begin
    vt[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000};
    vt[1]  = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001};
    vt[2]  = '{32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'b0001};
    vt[3]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101};
    vt[4]  = '{32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011};
    vt[5]  = '{32'h80800000, 32'h3F000000, 32'h80000000, 4'b0011};
    vt[6]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000};
    vt[7]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0000};
    vt[8]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000};
    vt[9]  = '{32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000};
    vt[10] = '{32'h80000000, 32'h7F800000, 32'h7FC00000, 4'b1000};
    vt[11] = '{32'h7FC00000, 32'h00000000, 32'h7FC00000, 4'b0000};
    vt[12] = '{32'h3F800000, 32'hBF800000, 32'hBF800000, 4'b0000};
    vt[13] = '{32'h3FFFFFFF, 32'h3F800001, 32'h40000000, 4'b0001};

    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0; a_i = '0; b_i = '0;
    h_valid_i = 1'b0; h_ready_i = 1'b1; h_a = '0; h_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("ready_o_in_reset", 36'(ready_o), 36'd1);
    rst_i = 1'b0;
    #1;
    check("reset_valid_o", 36'(valid_o), 36'd0);
    check("reset_c_flags", {flags_o, c_o}, 36'd0);
    check("reset_ready_o", 36'(ready_o), 36'd1);

    for (int i = 0; i < 14; i++)
      run_vec($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].c, vt[i].f);

    run_half("half_3p0", 16'h3E00, 16'h4000, 16'h4200, 4'b0000);
    run_half("half_ovf", 16'h7800, 16'h7800, 16'h7C00, 4'b0101);

    run_stream(100, 1'b0);
    run_stream(8, 1'b1);
    run_stream(40, 1'b1);

    // Mid-flight reset: fill the pipe with the consumer stalled, then reset
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid_i = 1'b1; a_i = gen(1'b0); b_i = gen(1'b0);
      step();
    end
    check("inflight_accepted", 36'(exp_q.size()), 36'd3);
    rst_i = 1'b1; valid_i = 1'b1; a_i = 32'h40000000; b_i = 32'h40000000;
    #1;
    check("ready_o_during_reset", 36'(ready_o), 36'd1);
    step();
    rst_i = 1'b0; valid_i = 1'b0;
    check("valid_o_after_reset", 36'(valid_o), 36'd0);
    exp_q.delete();
    n_out = 0;
    ready_i = 1'b1;
    repeat (6) step();
    check("no_stale_results", 36'(n_out), 36'd0);
    run_vec("post_reset", 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fmul_pipe.md
# fmul_pipe

Pipelined, parametrised IEEE-754-style floating-point multiplier with valid/ready handshaking. It is the successor to the combinational `fmul` and adds several things: a 3-stage pipeline with backpressure, round-to-nearest-even, special-value handling (zero, infinity, NaN), flush-to-zero of denormals, and exception flags. It sits between operand-producing logic and a downstream consumer in the datapath.

## Interface
- `EXP`, 8, exponent field width (≥3)
- `MANT`, 23, stored mantissa field width (≥2)
- `DATA_WIDTH`, 1+EXP+MANT, operand/result width
- `BIAS`, 2^(EXP-1)-1, exponent bias

Ports:
- `clk_i`  in  1  clock; all state is updated on the rising edge
- `rst_i`  in  1  reset, synchronous and active-high
- `valid_i`  in  1  operand pair valid
- `ready_o`  out  1  block accepts operands this cycle
- `a_i`  in  DATA_WIDTH  operand A
- `b_i`  in  DATA_WIDTH  operand B
- `valid_o`  out  1  result valid
- `ready_i`  in  1  consumer accepts result
- `c_o`  out  DATA_WIDTH  product
- `flags_o`  out  4  {invalid, overflow, underflow, inexact}, aligned with `c_o`

## Operation
- **Field decode:** sign = MSB, exponent = [DATA_WIDTH-2:MANT], fraction = [MANT-1:0].
- **Zero class:** exp=0 is zero; denormal inputs are flushed and their fraction is ignored.
- **Inf/NaN class:** exp all-ones with fraction 0 is inf; exp all-ones with fraction ≠0 is NaN.
- **Result sign:** sign_a ^ sign_b for every non-NaN result.
- **Special-case priority (highest first):**
  - any NaN input, or inf×zero → canonical qNaN {0, all-ones exp, 1, zeros}; invalid=1 only for inf×zero.
  - inf × (inf or finite) → signed inf, flags 0.
  - zero × finite → signed zero, flags 0.
- **Normal path, stage 1:** product of {1,frac_a}×{1,frac_b} is 2·MANT+2 bits. Exponent = exp_a+exp_b−BIAS, carried signed in EXP+2 bits.
- **Normal path, stage 2:** if product MSB=1, shift right 1 and exp+1. Extract MANT result bits, guard bit G, and sticky S = OR of all lower bits.
- **Normal path, stage 3 (RNE):** round up iff G & (S | lsb). Mantissa carry-out on round-up → mantissa=0, exp+1. inexact = G|S.
- **Overflow:** final exp ≥ 2^EXP−1 → signed inf; overflow=1, inexact=1.
- **Underflow:** final exp ≤ 0 → signed zero (flush-to-zero); underflow=1, inexact=1. Overflow and underflow are evaluated after rounding.

## Timing
- Three stages. Each stage carries a valid bit plus the special-case tag, sign, exponent, and mantissa data.
- Global advance: adv = ready_i | ~valid_o. ready_o = adv.
- **Transfer rules:** input transfer occurs when valid_i & ready_o; output transfer occurs when valid_o & ready_i.
- **Latency:** with ready_i held high, a result appears 3 cycles after acceptance. Throughput is 1 result/cycle.
- **Stall:** when adv=0, all stage registers hold. `c_o`, `flags_o`, and `valid_o` are stable until the result is accepted.
- **Bubbles:** bubbles propagate as valid=0. Bubble slots in stages 1–2 are not compacted during a stall; the global-enable scheme is accepted.
- **Ordering:** results leave in acceptance order. No drop or duplication under any valid_i/ready_i pattern.
- **Reset:** all stage valid bits, `valid_o`, `c_o`, and `flags_o` go to 0 on the cycle after `rst_i` is sampled high. Reset mid-operation discards in-flight results.
- **During reset:** `ready_o` = 1, but operands presented while `rst_i`=1 are discarded.

## Test plan
- **Basic multiply, ready_i=1:** 0x3FC00000 × 0x40000000 → c_o=0x40800000? No: 1.5×2.0=3.0 → c_o=0x40400000, flags 0, valid_o exactly 3 cycles after acceptance. Back-to-back stream of 100 random normals must match the reference model with RNE.
- **RNE tie cases:**
  - 0x3F800001 × 0x3FC00000 → 0x3FC00002 (tie, odd lsb rounds up), inexact=1.
  - 0x3F800003 × 0x3FC00000 → 0x3FC00004 (tie, even lsb holds), inexact=1.
- **Overflow/underflow:**
  - 0x7F000000 × 0x7F000000 → 0x7F800000, flags=0b0101.
  - 0x00800000 × 0x3F000000 → 0x00000000, flags=0b0011.
  - 0x80800000 × 0x3F000000 → 0x80000000, flags=0b0011.
- **Specials:**
  - 0x7F800000 × 0x00000000 → 0x7FC00000, flags=0b1000.
  - 0x7FC00001 × 0x3F800000 → 0x7FC00000, flags 0.
  - 0xFF800000 × 0x40000000 → 0xFF800000, flags 0.
  - 0x00000001 (denormal) × 0x3F800000 → 0x00000000, flags 0.
- **Backpressure:** stream 8 operands while ready_i toggles in a random pattern including 5-cycle low bursts. Required: all 8 results in order, `c_o`/`flags_o` stable while valid_o & ~ready_i, and ready_o low whenever valid_o & ~ready_i.
- **Reset mid-operation:** with 3 results in flight, assert rst_i for 1 cycle. Required: valid_o=0 next cycle, no stale result ever emerges, and a new operand accepted after reset emerges 3 cycles later.
- **Parametrisation:** EXP=5, MANT=10 (half precision): 0x3E00 × 0x4000 → 0x4200 (1.5×2=3.0), and 0x7800 × 0x7800 → 0x7C00 with overflow|inexact.
